// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder: pops skewed operand wavefronts from row FIFOs onto the PE array west edge
module systolic_row_feeder #(
  parameter int ROWS   = 4,
  parameter int BWIDTH = 8,
  parameter int LEN_W  = 6,
  parameter int CNT_W  = 7
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    START,
  input  logic [LEN_W-1:0]        LEN,
  input  logic [ROWS-1:0]         FIFO_EMPTY,
  input  logic [ROWS*BWIDTH-1:0]  FIFO_DOUT,
  output logic [ROWS-1:0]         FIFO_POPE,
  output logic [ROWS*BWIDTH-1:0]  A_OUT,
  output logic [ROWS-1:0]         A_VALID,
  output logic                    BUSY,
  output logic                    STALL,
  output logic                    DONE
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         t_q, t_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [ROWS-1:0]          active;
  logic                     blocked;
  logic [CNT_W-1:0]         len_ext, last_t;
  logic [ROWS*BWIDTH-1:0]   a_out_q, a_out_d;
  logic [ROWS-1:0]          a_valid_q;
  assign len_ext = CNT_W'(len_q);
  assign last_t  = len_ext + CNT_W'(ROWS - 2);
  // row r is inside its diagonal window for wavefront cycles r .. r+len-1
  always_comb begin
    active = '0;
    for (int r = 0; r < ROWS; r++)
      active[r] = (t_q >= CNT_W'(r)) && (t_q < CNT_W'(r) + len_ext);
  end
  assign blocked = |(active & FIFO_EMPTY);
  // next state, pops and stall; any dry active row freezes the whole wavefront
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    len_d     = len_q;
    FIFO_POPE = '0;
    STALL     = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        if (LEN != '0) begin
          len_d   = LEN;
          t_d     = '0;
          state_d = RUN;
        end else state_d = FIN;
      end
      RUN: begin
        STALL = blocked;
        if (!blocked) begin
          FIFO_POPE = active;
          t_d       = t_q + 1'b1;
          state_d   = (t_q == last_t) ? FIN : RUN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // head data is captured in the pop cycle; idle rows are zero padded
  always_comb begin
    a_out_d = '0;
    for (int r = 0; r < ROWS; r++)
      a_out_d[r*BWIDTH +: BWIDTH] = FIFO_POPE[r] ? FIFO_DOUT[r*BWIDTH +: BWIDTH] : '0;
  end
  // state, counter and edge registers; reset aborts any wavefront at once
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      t_q       <= '0;
      len_q     <= '0;
      a_out_q   <= '0;
      a_valid_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      len_q     <= len_d;
      a_out_q   <= a_out_d;
      a_valid_q <= FIFO_POPE;
    end
  end
  assign A_OUT   = a_out_q;
  assign A_VALID = a_valid_q;
  assign BUSY    = state_q != IDLE;
  assign DONE    = state_q == FIN;
endmodule

// File: doc/systolic_row_feeder.md
Name: systolic_row_feeder

Overview:
- Read-side controller for a bank of ROWS operand FIFOs that feed the west edge of the systolic PE array.
- On START it pops LEN operands from each row FIFO, with row r delayed r cycles to produce the diagonal skew the array needs.
- It registers the popped operands onto the array edge with per-row valid flags and zero padding.
- The whole wavefront stalls if any active row FIFO runs dry, so skew alignment is never broken.

Parameters:
- ROWS, 4, number of row FIFOs / PE rows driven
- BWIDTH, 8, operand width (INT8)
- LEN_W, 6, width of the vector-length field (max LEN = 2^LEN_W-1)
- CNT_W, 7, width of the wavefront counter; must satisfy 2^CNT_W > (2^LEN_W-1)+ROWS-1

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- START  in  1  single-cycle request to stream one vector set
- LEN  in  LEN_W  elements per row; sampled only when START is accepted
- FIFO_EMPTY  in  ROWS  per-row FIFO IS_EMPTY
- FIFO_DOUT  in  ROWS*BWIDTH  per-row FIFO head data (combinational D_out); row r at bits [r*BWIDTH +: BWIDTH]
- FIFO_POPE  out  ROWS  per-row pop enable to the FIFOs
- A_OUT  out  ROWS*BWIDTH  registered operands to the array edge; row r at bits [r*BWIDTH +: BWIDTH]
- A_VALID  out  ROWS  registered per-row operand valid
- BUSY  out  1  high in RUN and FIN
- STALL  out  1  combinational; high when RUN is blocked by an empty active FIFO
- DONE  out  1  one-cycle pulse coinciding with the last A_VALID

Behaviour:
- Reset: RSTn is asynchronous, active-low; CLK is the clock. On reset, state=IDLE, counter t=0, latched len=0, and A_OUT, A_VALID, BUSY, DONE, FIFO_POPE and STALL are all 0.
- Reset mid-operation aborts immediately. No pops occur after reset; the FIFOs keep their contents.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - START=1 with LEN>0: latch len=LEN, set t=0, go to RUN.
  - START=1 with LEN=0: go to FIN directly, with no pops and no valids.
  - START=0: stay in IDLE.
- START outside IDLE is ignored.
- RUN, row activity: active[r] = (t >= r) && (t < r+len), where t is the wavefront cycle index.
- RUN, blocking: blocked = OR over r of (active[r] & FIFO_EMPTY[r]).
- RUN, pops: FIFO_POPE[r] = RUN & active[r] & ~blocked, combinational. All active rows pop together or none do.
- RUN, STALL = RUN & blocked.
- RUN, counter: t increments only when not blocked.
- RUN, exit: when not blocked and t == len+ROWS-2 (the last pop cycle, row ROWS-1's final element), go to FIN; otherwise stay in RUN.
- Output register, updated every cycle:
  - A_VALID[r] <= FIFO_POPE[r]
  - A_OUT row r <= FIFO_POPE[r] ? FIFO_DOUT row r : 0
  - Latency: pop cycle n produces valid data at cycle n+1. Head data is sampled in the same cycle POPE is asserted.
  - When blocked, all A_VALID are 0 and A_OUT is 0 the next cycle. The wavefront slips uniformly, so relative skew is preserved.
- FIN: DONE=1 for exactly one cycle, then go to IDLE. This is the cycle of the final A_VALID[ROWS-1].
- BUSY = (state != IDLE).
- Counts: total pops per row = len exactly. Unstalled RUN duration = len+ROWS-1 cycles. START-to-DONE = len+ROWS cycles plus stall cycles.
- Arithmetic: comparisons on t use CNT_W-bit unsigned values and never wrap.
- The feeder never asserts POPE on an empty FIFO. An empty FIFO on a row that is not active does not block.

Test Plan:
- ROWS=4, LEN=3, all FIFOs preloaded with r*16+{1,2,3}; pulse START. FIFO_POPE patterns per cycle: 0001, 0011, 0111, 1110, 1100, 1000. A_VALID shows the same patterns one cycle later. Row 2 data is 0x21, 0x22, 0x23. DONE pulses on the 7th cycle after the START cycle. BUSY is high for 7 cycles.
- Same setup, but FIFO 1 holds only 1 element; push its second element 5 cycles after START. STALL=1 while waiting, with no POPE and all A_VALID=0. After the push, the pattern resumes unchanged. DONE is delayed by exactly the stall count, and each row pops exactly 3.
- LEN=0 START: no POPE. DONE pulses one cycle later. BUSY is high for 1 cycle.
- START re-pulsed mid-RUN with LEN=5: ignored. Pop count stays 3 per row.
- RSTn asserted during the 3rd RUN cycle: outputs go to 0 immediately and the FSM returns to IDLE. FIFO fronts advance only for pops that completed before reset.
- FIFO 3 empty while only rows 0–1 are active (t=0,1): no stall. The stall begins only at t=3 if FIFO 3 is still empty.
